// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, digit-select codes, error codes and capture FSM states
package seg7_pkg;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] EN_D0 = 4'b1110;
   localparam logic [3:0] EN_D1 = 4'b1101;
   localparam logic [3:0] EN_D2 = 4'b1011;
   localparam logic [3:0] EN_D3 = 4'b0111;
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_PAT  = 2'b01;
   localparam logic [1:0] ERR_EN   = 2'b10;
   localparam logic [1:0] ERR_SEQ  = 2'b11;
   typedef enum logic [2:0] {SYNC, D1, D2, D3, DONE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment pattern to BCD, blank maps to 4'hF
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] bcd,
   output logic       ok
);
   always_comb begin
      bcd = 4'h0;
      ok = 1'b1;
      case (pattern)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: bcd = 4'hF;
         default:   ok = 1'b0;
      endcase
   end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: debounces a scanned 4-digit 7-segment display and captures whole frames
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:1]  ENABLE,
   input  logic [7:0]  SEGMENT,
   output logic [15:0] DIGITS,
   output logic        VALID,
   output logic        ERROR,
   output logic [1:0]  ERR_CODE
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   logic [11:0] sync_a, sync_b, prev;
   logic [CW-1:0] cnt;
   logic [3:0] part0, part1, part2, bcd;
   logic [1:0] idx, code;
   logic pat_ok, en_ok, settle, good, start, err;
   state_t state, state_n;

   seg7_decode u_decode (.pattern(sync_b[6:0]), .bcd(bcd), .ok(pat_ok));

   // counter saturates one past the settle value so each stable run settles once
   assign settle = cnt == CW'(STABLE_CYCLES - 1);
   assign en_ok = sync_b[11:8] inside {EN_D0, EN_D1, EN_D2, EN_D3};
   assign idx = sync_b[11:8] == EN_D1 ? 2'd1 : sync_b[11:8] == EN_D2 ? 2'd2 : sync_b[11:8] == EN_D3 ? 2'd3 : 2'd0;
   assign good = settle && en_ok && pat_ok;
   assign start = good && idx == 2'd0;
   assign code = !en_ok ? ERR_EN : !pat_ok ? ERR_PAT : ERR_SEQ;

   always_comb begin
      state_n = state;
      err = 1'b0;
      if (state == SYNC || state == DONE)
         state_n = start ? D1 : SYNC;
      else if (good && idx == state[1:0])
         state_n = state == D1 ? D2 : state == D2 ? D3 : DONE;
      else if (settle) begin
         err = 1'b1;
         state_n = start ? D1 : SYNC;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_a <= 12'hFFF;
         sync_b <= 12'hFFF;
         prev <= 12'hFFF;
         cnt <= '0;
         state <= SYNC;
         part0 <= '0;
         part1 <= '0;
         part2 <= '0;
         DIGITS <= '0;
         VALID <= 1'b0;
         ERROR <= 1'b0;
         ERR_CODE <= ERR_NONE;
      end else begin
         sync_a <= {ENABLE, SEGMENT};
         sync_b <= sync_a;
         prev <= sync_b;
         cnt <= sync_b != prev ? '0 : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
         state <= state_n;
         part0 <= good && idx == 2'd0 ? bcd : part0;
         part1 <= good && idx == 2'd1 ? bcd : part1;
         part2 <= good && idx == 2'd2 ? bcd : part2;
         VALID <= state_n == DONE;
         ERROR <= err;
         ERR_CODE <= err ? code : ERR_CODE;
         DIGITS <= state_n == DONE ? {bcd, part2, part1, part0} : DIGITS;
      end
   end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: table-driven frames plus hand-built corner sequences, checked by an event scoreboard
module tb_seg7_scan_capture;
   localparam int N = 16;
   localparam int HOLD = 100;
   localparam logic [3:0] E0 = 4'b1110;
   localparam logic [3:0] E1 = 4'b1101;
   localparam logic [3:0] E2 = 4'b1011;
   localparam logic [3:0] E3 = 4'b0111;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic [4:1] ENABLE = 4'hF;
   logic [7:0] SEGMENT = 8'hFF;
   logic [15:0] DIGITS;
   logic VALID, ERROR;
   logic [1:0] ERR_CODE;
   int checks = 0;
   int failures = 0;
   int lat;

   typedef struct packed {
      logic        err;
      logic [1:0]  code;
      logic [15:0] digits;
   } ev_t;
   typedef struct {
      logic [3:0][3:0] en;
      logic [3:0][7:0] seg;
      ev_t             ev;
   } vec_t;

   ev_t q[$];
   ev_t mon_e;
   vec_t vecs[9];

   seg7_scan_capture #(.STABLE_CYCLES(N)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SEGMENT(SEGMENT),
      .DIGITS(DIGITS), .VALID(VALID), .ERROR(ERROR), .ERR_CODE(ERR_CODE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int n);
      ENABLE = en;
      SEGMENT = seg;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   always @(negedge CLK) begin
      if (!RESET && (VALID || ERROR)) begin
         check("valid_and_error", {15'd0, VALID & ERROR}, 16'd0);
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event valid=%b error=%b digits=%h", VALID, ERROR, DIGITS);
         end else begin
            mon_e = q.pop_front();
            check("event_kind", {15'd0, ERROR}, {15'd0, mon_e.err});
            check("digits", DIGITS, mon_e.digits);
            if (mon_e.err) check("err_code", {14'd0, ERR_CODE}, {14'd0, mon_e.code});
         end
      end
   end

   initial begin
      vecs[0] = '{{E3, E2, E1, E0}, {8'h19, 8'h24, 8'h30, 8'h40}, '{1'b0, 2'b00, 16'h4230}};
      vecs[1] = '{{E3, E2, E1, E0}, {8'hFF, 8'h7F, 8'hFF, 8'h7F}, '{1'b0, 2'b00, 16'hFFFF}};
      vecs[2] = '{{E3, E2, E1, E0}, {8'h82, 8'hF8, 8'h80, 8'h90}, '{1'b0, 2'b00, 16'h6789}};
      vecs[3] = '{{E3, E2, E1, E0}, {8'h19, 8'h55, 8'h79, 8'h40}, '{1'b1, 2'b01, 16'h6789}};
      vecs[4] = '{{E3, E2, E1, E0}, {8'h00, 8'h78, 8'h02, 8'h12}, '{1'b0, 2'b00, 16'h8765}};
      vecs[5] = '{{E1, E3, E1, E0}, {8'h79, 8'h19, 8'h79, 8'h40}, '{1'b1, 2'b11, 16'h8765}};
      vecs[6] = '{{E3, E2, E1, E0}, {8'h19, 8'h24, 8'h30, 8'h40}, '{1'b0, 2'b00, 16'h4230}};
      vecs[7] = '{{E3, 4'b1100, E1, E0}, {8'h19, 8'h55, 8'h79, 8'h40}, '{1'b1, 2'b10, 16'h4230}};
      vecs[8] = '{{E3, E2, E1, E0}, {8'h82, 8'hF8, 8'h80, 8'h90}, '{1'b0, 2'b00, 16'h6789}};
      repeat (3) @(posedge CLK);
      #1;
      check("reset_digits", DIGITS, 16'h0000);
      check("reset_valid", {15'd0, VALID}, 16'd0);
      check("reset_error", {15'd0, ERROR}, 16'd0);
      check("reset_err_code", {14'd0, ERR_CODE}, 16'd0);
      RESET = 1'b0;
      foreach (vecs[i]) begin
         q.push_back(vecs[i].ev);
         for (int j = 0; j < 4; j++) drive(vecs[i].en[j], vecs[i].seg[j], HOLD);
      end
      // a short 0x79 blip on digit1 must not be captured
      q.push_back('{1'b0, 2'b00, 16'h4230});
      drive(E0, 8'h40, HOLD);
      drive(E1, 8'h79, 10);
      drive(E1, 8'h30, HOLD);
      drive(E2, 8'h24, HOLD);
      drive(E3, 8'h19, HOLD);
      // out-of-order digit0 restarts the frame from itself
      q.push_back('{1'b1, 2'b11, 16'h4230});
      q.push_back('{1'b0, 2'b00, 16'h4321});
      drive(E0, 8'h40, HOLD);
      drive(E0, 8'h79, HOLD);
      drive(E1, 8'h24, HOLD);
      drive(E2, 8'h30, HOLD);
      drive(E3, 8'h19, HOLD);
      q.push_back('{1'b0, 2'b00, 16'h1234});
      drive(E0, 8'h19, HOLD);
      drive(E1, 8'h30, HOLD);
      drive(E2, 8'h24, HOLD);
      ENABLE = E3;
      SEGMENT = 8'h79;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge CLK);
         #1;
         if (VALID) lat = k;
      end
      check("digit3_to_valid_latency", 16'(lat), 16'(N + 3));
      drive(E3, 8'h79, 50);
      drive(E0, 8'h40, HOLD);
      drive(E1, 8'h79, HOLD);
      RESET = 1'b1;
      drive(E1, 8'h79, 2);
      check("midreset_digits", DIGITS, 16'h0000);
      check("midreset_valid", {15'd0, VALID}, 16'd0);
      check("midreset_error", {15'd0, ERROR}, 16'd0);
      check("midreset_err_code", {14'd0, ERR_CODE}, 16'd0);
      RESET = 1'b0;
      drive(E1, 8'h79, HOLD);
      q.push_back('{1'b0, 2'b00, 16'h4230});
      drive(E0, 8'h40, HOLD);
      drive(E1, 8'h30, HOLD);
      drive(E2, 8'h24, HOLD);
      drive(E3, 8'h19, HOLD);
      drive(E3, 8'h19, 50);
      check("pending_events", 16'(q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 16, the number of consecutive identical synchronized samples required before a digit is accepted.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ENABLE, input, [4:1]: active-low digit select.
  - 4'b1110 = digit0; 4'b1101 = digit1; 4'b1011 = digit2; 4'b0111 = digit3.
REQ-005 The block SHALL have port SEGMENT, input, [7:0]: active-low segments.
  - Bit 7 is the decimal point and is ignored.
  - Bits 6:0 are segments g..a.
REQ-006 The block SHALL have port DIGITS, output, [15:0]: last complete frame.
  - Digit0 is in bits [3:0], digit3 in bits [15:12].
REQ-007 The block SHALL have port VALID, output, 1 bit: one-cycle pulse when DIGITS updates.
REQ-008 The block SHALL have port ERROR, output, 1 bit: one-cycle pulse when a frame is discarded.
REQ-009 The block SHALL have port ERR_CODE, output, [1:0]: cause of the last error, held until the next error.
  - 2'b01 = bad pattern; 2'b10 = bad enable; 2'b11 = sequence error.

Function
REQ-010 ENABLE and SEGMENT SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 A stability counter SHALL increment while the synchronized {ENABLE,SEGMENT} equals its previous value, reset to 0 on any change, and saturate.
REQ-012 A settle event SHALL fire exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES-1.
REQ-013 SEGMENT[6:0] SHALL decode as follows; any other pattern SHALL be a bad pattern.
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4.
  - 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F (blank) → 4'hF.
REQ-014 On a settle event, an ENABLE value that is not one of the four codes (including 4'b1111) SHALL be a bad enable.
REQ-015 The FSM SHALL have five states: SYNC, D1, D2, D3, DONE.
  - SYNC waits for a valid digit0 event.
  - D1, D2 and D3 each expect the next digit in order 0,1,2,3.
REQ-016 In SYNC, settle events other than a valid digit0 SHALL be ignored, with no ERROR.
REQ-017 In states D1–D3, a settle event with a bad pattern, bad enable or out-of-order digit SHALL pulse ERROR the next cycle, set ERR_CODE, discard partial digits and return to SYNC.
  - Priority: bad enable > bad pattern > sequence error.
REQ-018 If the erroring event is itself a valid digit0, the FSM SHALL start a new frame from it (go to D1) rather than SYNC.
REQ-019 A valid digit3 event SHALL latch all four digits into DIGITS and pulse VALID on the following cycle, then return to D1-expectation via SYNC-free restart: the next expected digit is digit0.
REQ-020 Total latency from a digit3 input change to VALID SHALL be 2 (synchronizer) + STABLE_CYCLES + 1 cycles.
REQ-021 DIGITS SHALL change only on a VALID cycle; errors SHALL NOT alter DIGITS.
REQ-022 VALID and ERROR SHALL never be asserted in the same cycle.

Reset
REQ-023 On RESET, the following SHALL be set on the next CLK edge:
  - DIGITS=16'h0000, VALID=0, ERROR=0, ERR_CODE=2'b00.
  - Stability counter=0, FSM=SYNC.
  - Synchronizer flops = {4'b1111, 8'hFF}.
REQ-024 RESET asserted mid-frame SHALL discard partial digits with no ERROR pulse.

Structure
REQ-025 The shared package seg7_pkg SHALL hold the segment pattern constants, the ENABLE codes, the ERR_CODE values and the FSM state encoding.
REQ-026 Pattern→BCD decoding SHALL be a combinational sub-module, seg7_decode, with outputs bcd[3:0] and ok.

Verification
REQ-027 Clean frame: with STABLE_CYCLES=16, drive digits 0..3 as 0x40, 0x30, 0x24, 0x19, each held 100 cycles → exactly one VALID with DIGITS=16'h4230 and no ERROR.
REQ-028 Glitch rejection: hold digit1 pattern 0x79 for 10 cycles, then 0x30 for 100 cycles → digit1 captured as 3 and the 0x79 glitch is ignored.
REQ-029 Bad pattern: drive 0x55 on digit2 mid-frame → ERROR pulse with ERR_CODE=01, no VALID, and DIGITS unchanged.
REQ-030 Sequence error: drive digit0, digit1, then digit3 → ERROR with ERR_CODE=11; a following complete frame then yields VALID.
REQ-031 Bad enable and blank: ENABLE=4'b1100 in D2 → ERR_CODE=10; a frame with all digits blank → DIGITS=16'hFFFF.
REQ-032 Reset mid-frame: assert RESET after digit1 → all outputs 0 and no ERROR; the next full frame produces VALID.
